// File: rtl/sequential_divider_pkg.sv
// Shared ECO32 divider constants: default datapath width and the divider FSM encoding.
package sequential_divider_pkg;

    localparam int DIV_WIDTH = 32;

    typedef logic [1:0] div_state_t;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_FIXUP = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

endpackage

// File: rtl/sequential_divider_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial-subtract the divisor.
module divider_step
    import sequential_divider_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] partial,
    input  logic             dividend_bit,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] next_partial,
    output logic             quotient_bit
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    // partial < divisor always holds, so bit WIDTH of diff is a true borrow flag
    assign shifted = {partial, dividend_bit};
    assign diff    = shifted - {1'b0, divisor};

    always_comb begin
        if (diff[WIDTH]) begin
            next_partial = shifted[WIDTH-1:0];
            quotient_bit = 1'b0;
        end else begin
            next_partial = diff[WIDTH-1:0];
            quotient_bit = 1'b1;
        end
    end

endmodule

// File: rtl/sequential_divider.sv
// Radix-2 restoring divider for div/divu/rem/remu: one quotient bit per clock,
// sign correction in a final FIXUP cycle, results held until the next operation.
module sequential_divider
    import sequential_divider_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             signedMode,
    input  logic [WIDTH-1:0] leftOperand,
    input  logic [WIDTH-1:0] rightOperand,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             divideByZero
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

    div_state_t       state_reg;
    logic [CW-1:0]    count_reg;
    logic [WIDTH-1:0] partial_reg;
    logic [WIDTH-1:0] work_reg;
    logic [WIDTH-1:0] divisor_reg;
    logic             q_neg_reg;
    logic             r_neg_reg;
    logic             zero_div_reg;
    logic [WIDTH-1:0] quotient_reg;
    logic [WIDTH-1:0] remainder_reg;
    logic             dbz_reg;

    logic             left_neg;
    logic             right_neg;
    logic [WIDTH-1:0] left_mag;
    logic [WIDTH-1:0] right_mag;
    logic [WIDTH-1:0] step_partial;
    logic             step_qbit;

    // abs(most-negative) wraps to itself, which is the correct unsigned magnitude
    assign left_neg  = signedMode & leftOperand[WIDTH-1];
    assign right_neg = signedMode & rightOperand[WIDTH-1];
    assign left_mag  = left_neg  ? -leftOperand  : leftOperand;
    assign right_mag = right_neg ? -rightOperand : rightOperand;

    divider_step #(.WIDTH(WIDTH)) u_step (
        .partial      (partial_reg),
        .dividend_bit (work_reg[WIDTH-1]),
        .divisor      (divisor_reg),
        .next_partial (step_partial),
        .quotient_bit (step_qbit)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            count_reg     <= '0;
            partial_reg   <= '0;
            work_reg      <= '0;
            divisor_reg   <= '0;
            q_neg_reg     <= 1'b0;
            r_neg_reg     <= 1'b0;
            zero_div_reg  <= 1'b0;
            quotient_reg  <= '0;
            remainder_reg <= '0;
            dbz_reg       <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        // work_reg shifts the dividend out and the quotient in;
                        // on a zero divisor it just carries the raw dividend
                        state_reg    <= ST_RUN;
                        zero_div_reg <= (rightOperand == '0);
                        work_reg     <= (rightOperand == '0) ? leftOperand : left_mag;
                        divisor_reg  <= right_mag;
                        partial_reg  <= '0;
                        count_reg    <= LAST_COUNT;
                        q_neg_reg    <= left_neg ^ right_neg;
                        r_neg_reg    <= left_neg;
                    end
                end
                ST_RUN: begin
                    if (zero_div_reg) begin
                        quotient_reg  <= '0;
                        remainder_reg <= work_reg;
                        dbz_reg       <= 1'b1;
                        state_reg     <= ST_DONE;
                    end else begin
                        partial_reg <= step_partial;
                        work_reg    <= {work_reg[WIDTH-2:0], step_qbit};
                        if (count_reg == '0) begin
                            state_reg <= ST_FIXUP;
                        end else begin
                            count_reg <= count_reg - CW'(1);
                        end
                    end
                end
                ST_FIXUP: begin
                    quotient_reg  <= q_neg_reg ? -work_reg : work_reg;
                    remainder_reg <= r_neg_reg ? -partial_reg : partial_reg;
                    dbz_reg       <= 1'b0;
                    state_reg     <= ST_DONE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy         = (state_reg == ST_RUN) || (state_reg == ST_FIXUP);
    assign done         = (state_reg == ST_DONE);
    assign quotient     = quotient_reg;
    assign remainder    = remainder_reg;
    assign divideByZero = dbz_reg;

endmodule

// File: tb/tb_sequential_divider.sv
// Directed bench for sequential_divider: one line per operation, immediate-assertion checks.
module tb_sequential_divider;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        signedMode;
    logic [31:0] leftOperand;
    logic [31:0] rightOperand;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        divideByZero;

    int total_cnt = 0;
    int pass_cnt  = 0;

    sequential_divider #(.WIDTH(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .signedMode   (signedMode),
        .leftOperand  (leftOperand),
        .rightOperand (rightOperand),
        .busy         (busy),
        .done         (done),
        .quotient     (quotient),
        .remainder    (remainder),
        .divideByZero (divideByZero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total_cnt++;
        assert (observed === expected) pass_cnt++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    endtask

    // Issue one operation and follow it to completion.
    // poke_at: edge index after start at which a stray start with other operands is driven (0 = none)
    // start_in_done: drive start during the DONE cycle and confirm it is ignored
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b, input logic sm,
                          input logic [31:0] exp_q, input logic [31:0] exp_r, input logic exp_dbz,
                          input int exp_lat, input int poke_at, input bit start_in_done);
        int          n;
        logic        busy_bad;
        logic        hold_bad;
        logic [31:0] prev_q;
        @(negedge clk);
        leftOperand  = a;
        rightOperand = b;
        signedMode   = sm;
        start        = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        prev_q   = quotient;
        busy_bad = 1'b0;
        hold_bad = 1'b0;
        check({tag, " busy_after_start"}, 32'(busy), 32'd1);
        n = 0;
        while (n < 60) begin
            @(posedge clk);
            #1;
            n++;
            start = 1'b0;
            if (n == poke_at) begin
                start        = 1'b1;
                leftOperand  = 32'd100;
                rightOperand = 32'd7;
            end
            if (done) break;
            if (!busy) busy_bad = 1'b1;
            if (quotient !== prev_q) hold_bad = 1'b1;
        end
        start = 1'b0;
        check({tag, " latency"}, 32'(n), 32'(exp_lat));
        check({tag, " busy_while_running"}, 32'(busy_bad), 32'd0);
        check({tag, " outputs_held"}, 32'(hold_bad), 32'd0);
        check({tag, " quotient"}, quotient, exp_q);
        check({tag, " remainder"}, remainder, exp_r);
        check({tag, " divideByZero"}, 32'(divideByZero), 32'(exp_dbz));
        check({tag, " busy_at_done"}, 32'(busy), 32'd0);
        if (start_in_done) begin
            start        = 1'b1;
            leftOperand  = 32'd100;
            rightOperand = 32'd7;
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        check({tag, " done_one_cycle"}, 32'(done), 32'd0);
        check({tag, " idle_after_done"}, 32'(busy), 32'd0);
        $display("op %s: %08h / %08h signed=%0b -> q=%08h r=%08h dbz=%0b after %0d edges",
                 tag, a, b, sm, quotient, remainder, divideByZero, n);
    endtask

    initial begin
        int   n;
        logic seen_done;
        reset        = 1'b1;
        start        = 1'b0;
        signedMode   = 1'b0;
        leftOperand  = '0;
        rightOperand = '0;
        #12;
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset quotient", quotient, 32'd0);
        check("reset remainder", remainder, 32'd0);
        check("reset divideByZero", 32'(divideByZero), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        run_op("udiv_1000_5",   32'd1000,       32'd5,          1'b0, 32'd200,        32'd0,          1'b0, 33, 0, 0);
        run_op("sdiv_m7_2",     32'hFFFFFFF9,   32'd2,          1'b1, 32'hFFFFFFFD,   32'hFFFFFFFF,   1'b0, 33, 0, 0);
        run_op("udiv_m7_2",     32'hFFFFFFF9,   32'd2,          1'b0, 32'h7FFFFFFC,   32'd1,          1'b0, 33, 0, 0);
        run_op("sdiv_by_zero",  32'h12345678,   32'd0,          1'b1, 32'd0,          32'h12345678,   1'b1, 1,  0, 0);
        run_op("udiv_by_zero",  32'h12345678,   32'd0,          1'b0, 32'd0,          32'h12345678,   1'b1, 1,  0, 0);
        run_op("sdiv_overflow", 32'h80000000,   32'hFFFFFFFF,   1'b1, 32'h80000000,   32'd0,          1'b0, 33, 0, 0);
        run_op("udiv_equal",    32'hFFFFFFFE,   32'hFFFFFFFE,   1'b0, 32'd1,          32'd0,          1'b0, 33, 0, 0);
        run_op("start_in_run",  32'd1000,       32'd5,          1'b0, 32'd200,        32'd0,          1'b0, 33, 5, 1);
        run_op("after_done",    32'd45,         32'd6,          1'b0, 32'd7,          32'd3,          1'b0, 33, 0, 0);

        // asynchronous reset in the middle of an operation
        @(negedge clk);
        leftOperand  = 32'd1000;
        rightOperand = 32'd5;
        signedMode   = 1'b0;
        start        = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check("midrun_reset busy", 32'(busy), 32'd0);
        check("midrun_reset done", 32'(done), 32'd0);
        check("midrun_reset quotient", quotient, 32'd0);
        check("midrun_reset remainder", remainder, 32'd0);
        @(negedge clk);
        reset     = 1'b0;
        seen_done = 1'b0;
        for (n = 0; n < 40; n++) begin
            @(posedge clk);
            #1;
            if (done || busy) seen_done = 1'b1;
        end
        check("midrun_reset no_done", 32'(seen_done), 32'd0);
        $display("op midrun_reset: aborted, no completion in 40 edges");

        run_op("udiv_100_7",    32'd100,        32'd7,          1'b0, 32'd14,         32'd2,          1'b0, 33, 0, 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/sequential_divider.md
Name: sequential_divider

Overview:
- Iterative 32-bit integer divider for the ECO32 CPU execute stage; it is the inverse counterpart of the combinational multiplier.
- Serves div/divu/rem/remu: one start request yields quotient and remainder together.
- Radix-2 restoring algorithm, one quotient bit per clock; the CPU stalls on busy.

Parameters:
- WIDTH, 32, operand/result width in bits (ECO32 uses 32 only; parameter exists for reduced-width bench runs).

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  asynchronous, active-high reset
- start  input  1  request pulse; sampled only in IDLE
- signedMode  input  1  1 = div/rem (two's complement), 0 = divu/remu
- leftOperand  input  WIDTH  dividend, sampled with start
- rightOperand  input  WIDTH  divisor, sampled with start
- busy  output  1  high from the cycle after start is accepted until done
- done  output  1  one-cycle pulse, results valid
- quotient  output  WIDTH  result quotient, held until next accepted start
- remainder  output  WIDTH  result remainder, held until next accepted start
- divideByZero  output  1  valid with done; CPU raises the divide trap

Behaviour:
- Reset (async, any state): state=IDLE; busy=0, done=0, quotient=0, remainder=0, divideByZero=0, iteration counter=0.
- States: IDLE, RUN, FIXUP, DONE.
- IDLE, start=1 at edge E0:
  - Latch operand magnitudes: abs() in signed mode, raw in unsigned.
  - Latch sign flags: qNeg = signs differ, rNeg = dividend negative.
  - Clear the partial remainder, counter=WIDTH-1.
  - Go to RUN; busy=1.
  - If rightOperand==0: go directly to DONE with divideByZero=1, quotient=0, remainder=leftOperand. done is high after E1.
- RUN, one iteration per edge (E1..E32 for WIDTH=32):
  - Shift {remainder, dividend} left by 1.
  - Trial-subtract the divisor. If no borrow, keep the difference and set quotient bit=1; otherwise restore and set it to 0.
  - Counter decrements; at counter==0 go to FIXUP.
- FIXUP (E33):
  - Negate the quotient if qNeg; negate the remainder if rNeg.
  - Unsigned mode skips both negations.
  - Register the outputs and go to DONE.
- DONE: done=1, busy=0 for exactly one cycle (after E33), then IDLE at E34.
- Latency: done rises WIDTH+1 edges after the start edge; divide-by-zero rises 1 edge after.
- Signed semantics:
  - Quotient truncates toward zero.
  - Remainder takes the sign of the dividend.
  - Invariant: left == quotient*right + remainder (mod 2^WIDTH).
- Overflow: 0x80000000 / 0xFFFFFFFF in signed mode yields quotient=0x80000000, remainder=0, divideByZero=0, with no trap. abs(0x80000000) is treated as unsigned 0x80000000.
- start while busy or in DONE: ignored; operands are not re-sampled.
- start in the DONE cycle itself: ignored. The CPU must re-issue from IDLE.
- Outputs quotient/remainder/divideByZero change only in FIXUP or on the zero-divisor path.
- Internal partial values are not visible on the outputs mid-operation.
- Reset mid-RUN: operation aborted, no done pulse, outputs zeroed.

Decomposition:
- Shared package/include (eco32 cpu constants): WIDTH default, divider state encoding (IDLE=0, RUN=1, FIXUP=2, DONE=3).
- Sub-module divider_step: combinational single iteration.
  - Inputs: partial remainder, next dividend bit, divisor.
  - Outputs: new partial remainder, quotient bit.
  - Instanced once inside sequential_divider.
- Sign handling, counter and FSM stay in sequential_divider.

Test Plan:
- Unsigned 1000/5 (signedMode=0) -> quotient=200, remainder=0, done exactly 33 edges after the start edge, busy high in between.
- Signed 0xFFFFFFF9 (-7) / 2 -> quotient=0xFFFFFFFD (-3), remainder=0xFFFFFFFF (-1). Same operands unsigned -> quotient=0x7FFFFFFC, remainder=1.
- Zero divisor: 0x12345678 / 0, both modes -> done one edge after start, divideByZero=1, quotient=0, remainder=0x12345678.
- Signed overflow 0x80000000 / 0xFFFFFFFF -> quotient=0x80000000, remainder=0, divideByZero=0. Unsigned 0xFFFFFFFE/0xFFFFFFFE -> quotient=1, remainder=0.
- start re-asserted with different operands during RUN -> ignored, original result delivered. start in the DONE cycle -> ignored, next start in IDLE accepted.
- reset asserted asynchronously (between edges) at iteration 10 -> busy/done/results 0 immediately. No done pulse follows. A subsequent 100/7 returns quotient=14, remainder=2.
